// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto a single usart transmitter using the Tx_RDY / n_WR handshake.
// Round-robin by default; defining UART_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TMO_CYCLES = 16
) (
  input  logic               CLK50M,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   GNT,
  input  logic               Tx_RDY,
  output logic [7:0]         DATA_IN,
  output logic               n_WR,
  output logic               BUSY,
  output logic [2:0]         LAST_GNT,
  output logic               ERR
);

  localparam int TW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic            win_found;
  logic [2:0]      win_idx;
  logic [7:0]      win_data;
  logic [N_REQ-1:0] win_oh;

  // Winner selection: the lowest active index is the fixed-priority answer and also the
  // wrap-around fallback for round-robin when nothing above LAST_GNT is requesting.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    win_oh    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && REQ[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_data  = REQ_DATA[8*i +: 8];
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
`ifdef UART_ARB_FIXED_PRIO_EN
`else
    begin : rr_search
      logic hi_found;
      hi_found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (!hi_found && REQ[i] && (3'(i) > LAST_GNT)) begin
          hi_found  = 1'b1;
          win_idx   = 3'(i);
          win_data  = REQ_DATA[8*i +: 8];
          win_oh    = '0;
          win_oh[i] = 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      GNT      <= '0;
      n_WR     <= 1'b1;
      DATA_IN  <= 8'h00;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      tmo_cnt  <= '0;
      LAST_GNT <= 3'(N_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      GNT  <= '0;
      n_WR <= 1'b1;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found && Tx_RDY) begin
            GNT      <= win_oh;
            n_WR     <= 1'b0;
            DATA_IN  <= win_data;
            LAST_GNT <= win_idx;
            BUSY     <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!Tx_RDY) begin
            state <= WAIT_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            // The usart never acknowledged the write; give up so other requesters are not blocked.
            if (tmo_cnt == TW'(TMO_CYCLES - 1)) begin
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (Tx_RDY) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single transfers plus hand-written
// sequences for timeout, Tx_RDY-low stall, reset mid-transfer and back-to-back frames.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;
`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  localparam logic [8*N-1:0] DATA_NOM = {8'h4C, 8'hA7, 8'h3E, 8'h55};

  logic           tb_CLK50M = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           tx_rdy;
  logic [7:0]     data_in;
  logic           n_wr;
  logic           busy;
  logic [2:0]     last_gnt;
  logic           err;

  logic usart_en;
  logic man_rdy;
  logic model_rdy = 1'b1;
  int   u_cnt     = 0;
  int   frame_len = 4;

  int n_vec = 0;
  int n_bad = 0;

  always #10 tb_CLK50M = ~tb_CLK50M;

  assign tx_rdy = usart_en ? model_rdy : man_rdy;

  uart_tx_arbiter #(.N_REQ(N), .TMO_CYCLES(TMO)) dut (
    .CLK50M   (tb_CLK50M),
    .RST      (rst),
    .REQ      (req),
    .REQ_DATA (req_data),
    .GNT      (gnt),
    .Tx_RDY   (tx_rdy),
    .DATA_IN  (data_in),
    .n_WR     (n_wr),
    .BUSY     (busy),
    .LAST_GNT (last_gnt),
    .ERR      (err)
  );

  // usart model: Tx_RDY falls two cycles after the write strobe and rises frame_len cycles later.
  always @(negedge tb_CLK50M) begin
    if (!usart_en) begin
      u_cnt     = 0;
      model_rdy = 1'b1;
    end else if (u_cnt == 0) begin
      if (!n_wr) u_cnt = 1;
    end else begin
      u_cnt++;
      if (u_cnt == 3) model_rdy = 1'b0;
      if (u_cnt == 3 + frame_len) begin
        model_rdy = 1'b1;
        u_cnt     = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_CLK50M);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},      32'(gnt),      32'h0);
    check({tag, "_n_wr"},     32'(n_wr),     32'h1);
    check({tag, "_data_in"},  32'(data_in),  32'h00);
    check({tag, "_busy"},     32'(busy),     32'h0);
    check({tag, "_err"},      32'(err),      32'h0);
    check({tag, "_last_gnt"}, 32'(last_gnt), 32'h3);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [1:0]   exp_rr;
    logic [1:0]   exp_fp;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_bytes[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   e;
    logic [N-1:0] oh;
    int           bad;
    int           k;
    logic [1:0]   exp_seq_rr[5];

    vecs[0] = '{4'b0001, 2'd0, 2'd0};
    vecs[1] = '{4'b1111, 2'd1, 2'd0};
    vecs[2] = '{4'b1001, 2'd3, 2'd0};
    vecs[3] = '{4'b0110, 2'd1, 2'd1};
    vecs[4] = '{4'b0010, 2'd1, 2'd1};
    vecs[5] = '{4'b0001, 2'd0, 2'd0};
    exp_bytes  = '{8'h55, 8'h3E, 8'hA7, 8'h4C};
    exp_seq_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst       = 1'b1;
    req       = '0;
    req_data  = DATA_NOM;
    usart_en  = 1'b1;
    man_rdy   = 1'b1;
    frame_len = 4;
    repeat (3) tick();
    check_reset_outputs("rst");
    @(negedge tb_CLK50M);
    rst = 1'b0;

    // Single transfers; the arbitration pointer carries over from one vector to the next.
    for (int v = 0; v < 6; v++) begin
      @(negedge tb_CLK50M);
      req      = vecs[v].req;
      req_data = DATA_NOM;
      tick();
      e  = FP ? vecs[v].exp_fp : vecs[v].exp_rr;
      oh = 4'b0001 << e;
      check("vec_gnt",      32'(gnt),      32'(oh));
      check("vec_n_wr_low", 32'(n_wr),     32'h0);
      check("vec_data_in",  32'(data_in),  32'(exp_bytes[e]));
      check("vec_last_gnt", 32'(last_gnt), 32'(e));
      check("vec_busy",     32'(busy),     32'h1);
      req      = '0;
      req_data = {N{8'hEE}};
      tick();
      check("vec_gnt_pulse",  32'(gnt),     32'h0);
      check("vec_n_wr_pulse", 32'(n_wr),    32'h1);
      check("vec_data_hold",  32'(data_in), 32'(exp_bytes[e]));
      wait_idle(200);
      req_data = DATA_NOM;
    end

    // Timeout: Tx_RDY never falls after the write strobe.
    usart_en = 1'b0;
    man_rdy  = 1'b1;
    @(negedge tb_CLK50M);
    req = 4'b0001;
    tick();
    check("tmo_gnt", 32'(gnt), 32'h1);
    req = '0;
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (err !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("tmo_no_early_err", 32'(bad), 32'd0);
    tick();
    check("tmo_err_pulse", 32'(err),  32'h1);
    check("tmo_busy_low",  32'(busy), 32'h0);
    tick();
    check("tmo_err_one_cycle", 32'(err), 32'h0);

    // Transmitter not ready: nothing may be granted until Tx_RDY rises.
    man_rdy = 1'b0;
    @(negedge tb_CLK50M);
    req = 4'b0001;
    bad = 0;
    repeat (50) begin
      tick();
      if (gnt !== '0 || n_wr !== 1'b1) bad++;
    end
    check("stall_no_gnt", 32'(bad), 32'd0);
    @(negedge tb_CLK50M);
    man_rdy = 1'b1;
    tick();
    check("stall_gnt_after_rdy", 32'(gnt), 32'h1);
    req = '0;
    @(negedge tb_CLK50M);
    man_rdy = 1'b0;
    repeat (3) @(negedge tb_CLK50M);
    man_rdy = 1'b1;
    wait_idle(20);

    // Reset while in WAIT_DONE with requester 1 pending.
    @(negedge tb_CLK50M);
    req = 4'b0001;
    tick();
    check("rstmid_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    @(negedge tb_CLK50M);
    man_rdy = 1'b0;
    repeat (3) tick();
    check("rstmid_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    @(negedge tb_CLK50M);
    rst     = 1'b0;
    man_rdy = 1'b1;
    tick();
    check("rstmid_next_gnt",  32'(gnt),      32'h2);
    check("rstmid_last_gnt",  32'(last_gnt), 32'h1);
    req = '0;
    @(negedge tb_CLK50M);
    man_rdy = 1'b0;
    repeat (3) @(negedge tb_CLK50M);
    man_rdy = 1'b1;
    wait_idle(20);

    // Back-to-back frames with every requester held high.
    @(negedge tb_CLK50M);
    rst = 1'b1;
    @(negedge tb_CLK50M);
    rst       = 1'b0;
    usart_en  = 1'b1;
    frame_len = 100;
    req       = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (gnt == '0 && k < 400);
      e  = FP ? 2'd0 : exp_seq_rr[f];
      oh = 4'b0001 << e;
      check("b2b_gnt", 32'(gnt), 32'(oh));
      if (f > 0) check("b2b_interval", 32'(k), 32'd104);
    end
    req = '0;
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TMO_CYCLES, default 16, maximum cycles to wait for Tx_RDY to fall after a write strobe.
REQ-003 SHALL have port CLK50M  in  1  system clock, 50 MHz, all state on rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous active-high reset.
REQ-005 SHALL have port REQ  in  N_REQ  per-requester transmit request, level.
REQ-006 SHALL have port REQ_DATA  in  8*N_REQ  byte for requester i in bits [8i+7:8i].
REQ-007 SHALL have port GNT  out  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-008 SHALL have port Tx_RDY  in  1  usart transmitter idle (high = idle).
REQ-009 SHALL have port DATA_IN  out  8  byte to usart.
REQ-010 SHALL have port n_WR  out  1  active-low usart write strobe.
REQ-011 SHALL have port BUSY  out  1  high whenever state is not IDLE.
REQ-012 SHALL have port LAST_GNT  out  3  index of most recently granted requester.
REQ-013 SHALL have port ERR  out  1  one-cycle pulse on Tx_RDY handshake timeout.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-015 IDLE: when any REQ bit high and Tx_RDY high at a rising edge, SHALL select a winner, load DATA_IN from winner's REQ_DATA, update LAST_GNT, go to WRITE.
REQ-016 IDLE with Tx_RDY low SHALL grant nothing and remain in IDLE.
REQ-017 WRITE: SHALL hold n_WR low and GNT[winner] high for exactly one cycle, then go to WAIT_BUSY.
REQ-018 Latency: requester sampled at edge k SHALL see GNT and n_WR low during cycle k+1 to k+2.
REQ-019 WAIT_BUSY: Tx_RDY low SHALL move to WAIT_DONE; otherwise counter increments; reaching TMO_CYCLES SHALL pulse ERR one cycle and return to IDLE.
REQ-020 WAIT_DONE: Tx_RDY high SHALL return to IDLE; no timeout in this state.
REQ-021 Default arbitration SHALL be round-robin: search starts at LAST_GNT+1 modulo N_REQ, first high REQ wins.
REQ-022 DATA_IN SHALL stay constant from grant until next grant; REQ_DATA changes after selection SHALL be ignored.
REQ-023 Requester SHALL hold REQ and REQ_DATA until GNT; REQ withdrawn before selection SHALL be permitted and not granted.
REQ-024 REQ bits changing while BUSY SHALL not affect the current transfer; they are evaluated on return to IDLE.
REQ-025 Back-to-back: a REQ still high on return to IDLE SHALL be considered in the same edge as the IDLE transition out.
REQ-026 Timeout counter SHALL be width ceil(log2(TMO_CYCLES+1)) and clear on entry to WAIT_BUSY.

Reset
REQ-027 RST high SHALL asynchronously force IDLE, n_WR=1, GNT=0, DATA_IN=0x00, BUSY=0, ERR=0, timeout counter=0, LAST_GNT=N_REQ-1.
REQ-028 RST mid-transfer SHALL abandon the transfer without GNT; usart frame in progress is not aborted by this block.
REQ-029 First grant after reset SHALL be the lowest-index active requester.

Configuration
REQ-030 Macro UART_ARB_FIXED_PRIO_EN defined: SHALL use fixed priority, lowest index wins; LAST_GNT still updated.
REQ-031 Macro UART_ARB_FIXED_PRIO_EN undefined: SHALL use round-robin per REQ-021.

Verification
REQ-032 Reset, REQ=0001, data0=0x55, Tx_RDY=1 -> GNT=0001 and n_WR low one cycle, DATA_IN=0x55, LAST_GNT=0.
REQ-033 REQ=1111 held, usart model drops Tx_RDY 2 cycles after n_WR, 100-cycle frame -> grants 0,1,2,3,0 in order, one per frame.
REQ-034 Tx_RDY never falls after write -> ERR pulse 16 cycles after WAIT_BUSY entry, state IDLE, BUSY=0.
REQ-035 RST asserted during WAIT_DONE with REQ=0010 -> outputs at reset values immediately, next grant requester 1 after release.
REQ-036 UART_ARB_FIXED_PRIO_EN defined, REQ=0101 held -> requester 0 granted every frame, requester 2 starved.
REQ-037 Tx_RDY=0 with REQ=0001 for 50 cycles -> no GNT, n_WR high; Tx_RDY rises -> GNT after one edge.
